packet_responder32: RTL and testbench

- Far-end responder for the 36-bit generator/verifier packet stream.
- Consumes test packets on a 36-bit FIFO-style input and checks each one for length, sequence number and additive checksum.
- After each received packet, returns one fixed 4-word acknowledgement packet on a 36-bit output. The originating side can then close the loop without a separate verifier.
- Sits at the DUT end of a loopback link, e.g. behind a SERDES or Ethernet path under test.

---
 rtl/packet32_pkg.sv | 48 ++++
 rtl/packet32_ack_tx.sv | 50 +++++
 rtl/packet_responder32.sv | 188 ++++++++++++++++++
 tb/tb_packet_responder32.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet32_pkg.sv
// Shared definitions for the 36-bit packet generator/verifier stream and its responder.
package packet32_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BUS_W     = 36;
  localparam int unsigned LEN_W     = 16;
  localparam int unsigned SOF_BIT   = 32;
  localparam int unsigned EOF_BIT   = 33;
  localparam int unsigned ACK_LEN   = 4;
  localparam int unsigned ACK_IDX_W = 2;
  localparam int unsigned STAT_W    = 3;

  localparam int unsigned SUM_ERR = 0;
  localparam int unsigned LEN_ERR = 1;
  localparam int unsigned SEQ_ERR = 2;

  typedef enum logic [2:0] {IDLE, SEQ, BODY, DRAIN, ACK} state_t;

  typedef struct packed {
    logic [1:0]        rsvd;
    logic              eof;
    logic              sof;
    logic [WORD_W-1:0] data;
  } bus_word_t;

  // Ack word at position idx; the last word carries the post-increment packet count.
  function automatic bus_word_t ack_word(input logic [ACK_IDX_W-1:0] idx,
                                         input logic [WORD_W-1:0]    seq,
                                         input logic [STAT_W-1:0]    status,
                                         input logic [WORD_W-1:0]    total);
    bus_word_t w;
    w = '0;
    case (idx)
      2'd0: begin
        w.sof  = 1'b1;
        w.data = WORD_W'(ACK_LEN);
      end
      2'd1: w.data = seq;
      2'd2: w.data = WORD_W'(status);
      default: begin
        w.eof  = 1'b1;
        w.data = total + 32'd1;
      end
    endcase
    return w;
  endfunction

endpackage

// File: rtl/packet32_ack_tx.sv
// Four-word acknowledgement serializer: holds the word index, output word and handshake.
module packet32_ack_tx
  import packet32_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              start,
  input  logic [WORD_W-1:0] seq,
  input  logic [STAT_W-1:0] status,
  input  logic [WORD_W-1:0] total,
  output logic [BUS_W-1:0]  data_o,
  output logic              src_rdy_o,
  input  logic              dst_rdy_i,
  output logic              done_c
);

  logic [ACK_IDX_W-1:0] idx_q;
  bus_word_t            word_q;
  logic                 fire_c;

  assign fire_c = src_rdy_o && dst_rdy_i;
  assign done_c = fire_c && (idx_q == ACK_IDX_W'(ACK_LEN - 1));
  assign data_o = word_q;

  // Word register only moves on a transfer, so data_o holds under backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q     <= '0;
      word_q    <= '0;
      src_rdy_o <= 1'b0;
    end else if (clear) begin
      idx_q     <= '0;
      word_q    <= '0;
      src_rdy_o <= 1'b0;
    end else if (start) begin
      idx_q     <= '0;
      word_q    <= ack_word(ACK_IDX_W'(0), seq, status, total);
      src_rdy_o <= 1'b1;
    end else if (done_c) begin
      idx_q     <= '0;
      word_q    <= '0;
      src_rdy_o <= 1'b0;
    end else if (fire_c) begin
      idx_q     <= idx_q + ACK_IDX_W'(1);
      word_q    <= ack_word(idx_q + ACK_IDX_W'(1), seq, status, total);
    end
  end

endmodule

// File: rtl/packet_responder32.sv
// Far-end responder: checks length, sequence and checksum of each packet and returns a 4-word ack.
module packet_responder32
  import packet32_pkg::*;
#(
  parameter logic [LEN_W-1:0] MAX_LEN = 16'd2048
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [BUS_W-1:0]  data_i,
  input  logic              src_rdy_i,
  output logic              dst_rdy_o,
  output logic [BUS_W-1:0]  data_o,
  output logic              src_rdy_o,
  input  logic              dst_rdy_i,
  output logic [WORD_W-1:0] total,
  output logic [WORD_W-1:0] seq_errs,
  output logic [WORD_W-1:0] len_errs,
  output logic [WORD_W-1:0] sum_errs
);

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d, cnt_q, cnt_d;
  logic [WORD_W-1:0]   sum_q, sum_d, exp_seq_q, exp_seq_d, seq_lat_q, seq_lat_d;
  logic [STAT_W-1:0]   flags_q, flags_d;
  logic [WORD_W-1:0]   total_q, total_d, seq_errs_q, seq_errs_d;
  logic [WORD_W-1:0]   len_errs_q, len_errs_d, sum_errs_q, sum_errs_d;
  logic                dst_rdy_d, start_c, done_c;

  logic [WORD_W-1:0]   in_data;
  logic                in_sof, in_eof, in_fire, len_bad, last_c, unused_rsvd;

  assign in_data     = data_i[WORD_W-1:0];
  assign in_sof      = data_i[SOF_BIT];
  assign in_eof      = data_i[EOF_BIT];
  assign unused_rsvd = ^data_i[BUS_W-1:EOF_BIT+1];
  assign in_fire     = src_rdy_i && dst_rdy_o;
  assign len_bad     = (in_data < 32'd3) || (in_data > WORD_W'(MAX_LEN));
  assign last_c      = (cnt_q == len_q - LEN_W'(1));

  assign total    = total_q;
  assign seq_errs = seq_errs_q;
  assign len_errs = len_errs_q;
  assign sum_errs = sum_errs_q;

  // Checker next-state logic; clear forces every register back to its reset value.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    exp_seq_d  = exp_seq_q;
    seq_lat_d  = seq_lat_q;
    flags_d    = flags_q;
    total_d    = total_q;
    seq_errs_d = seq_errs_q;
    len_errs_d = len_errs_q;
    sum_errs_d = sum_errs_q;

    case (state_q)
      IDLE: begin
        if (in_fire && in_sof) begin
          len_d     = in_data[LEN_W-1:0];
          sum_d     = in_data;
          cnt_d     = LEN_W'(1);
          seq_lat_d = '0;
          if (len_bad || in_eof) begin
            flags_d[LEN_ERR] = 1'b1;
            state_d          = in_eof ? ACK : DRAIN;
          end else begin
            state_d = SEQ;
          end
        end
      end
      SEQ: begin
        if (in_fire) begin
          sum_d     = sum_q + in_data;
          cnt_d     = cnt_q + LEN_W'(1);
          seq_lat_d = in_data;
          exp_seq_d = in_data + 32'd1;
          if (in_data != exp_seq_q) flags_d[SEQ_ERR] = 1'b1;
          if (in_eof) begin
            flags_d[LEN_ERR] = 1'b1;
            state_d          = ACK;
          end else begin
            state_d = BODY;
          end
        end
      end
      BODY: begin
        if (in_fire) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (last_c && in_eof) begin
            flags_d[SUM_ERR] = (in_data != sum_q);
            state_d          = ACK;
          end else begin
            sum_d = sum_q + in_data;
            if (in_eof) begin
              flags_d[LEN_ERR] = 1'b1;
              state_d          = ACK;
            end else if (last_c) begin
              flags_d[LEN_ERR] = 1'b1;
              state_d          = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (in_fire && in_eof) state_d = ACK;
      end
      ACK: begin
        if (done_c) begin
          total_d    = total_q + 32'd1;
          seq_errs_d = seq_errs_q + WORD_W'(flags_q[SEQ_ERR]);
          len_errs_d = len_errs_q + WORD_W'(flags_q[LEN_ERR]);
          sum_errs_d = sum_errs_q + WORD_W'(flags_q[SUM_ERR]);
          flags_d    = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    start_c = (state_q != ACK) && (state_d == ACK);

    if (clear) begin
      state_d    = IDLE;
      len_d      = '0;
      cnt_d      = '0;
      sum_d      = '0;
      exp_seq_d  = '0;
      seq_lat_d  = '0;
      flags_d    = '0;
      total_d    = '0;
      seq_errs_d = '0;
      len_errs_d = '0;
      sum_errs_d = '0;
      start_c    = 1'b0;
    end

    dst_rdy_d = (state_d != ACK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      exp_seq_q  <= '0;
      seq_lat_q  <= '0;
      flags_q    <= '0;
      total_q    <= '0;
      seq_errs_q <= '0;
      len_errs_q <= '0;
      sum_errs_q <= '0;
      dst_rdy_o  <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      exp_seq_q  <= exp_seq_d;
      seq_lat_q  <= seq_lat_d;
      flags_q    <= flags_d;
      total_q    <= total_d;
      seq_errs_q <= seq_errs_d;
      len_errs_q <= len_errs_d;
      sum_errs_q <= sum_errs_d;
      dst_rdy_o  <= dst_rdy_d;
    end
  end

  packet32_ack_tx u_ack_tx (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .start     (start_c),
    .seq       (seq_lat_q),
    .status    (flags_d),
    .total     (total_q),
    .data_o    (data_o),
    .src_rdy_o (src_rdy_o),
    .dst_rdy_i (dst_rdy_i),
    .done_c    (done_c)
  );

endmodule

// File: tb/tb_packet_responder32.sv
// Bench for packet_responder32: directed vector table, corner sequences, then randomized packets vs a reference model.
module tb_packet_responder32;

  logic        clk = 1'b0;
  logic        reset_n, clear, src_rdy_i, dst_rdy_o, src_rdy_o, dst_rdy_i;
  logic [35:0] data_i, data_o;
  logic [31:0] total, seq_errs, len_errs, sum_errs;

  always #5 clk = ~clk;

  packet_responder32 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .data_i    (data_i),
    .src_rdy_i (src_rdy_i),
    .dst_rdy_o (dst_rdy_o),
    .data_o    (data_o),
    .src_rdy_o (src_rdy_o),
    .dst_rdy_i (dst_rdy_i),
    .total     (total),
    .seq_errs  (seq_errs),
    .len_errs  (len_errs),
    .sum_errs  (sum_errs)
  );

  int n_total = 0;
  int n_bad   = 0;

  logic [35:0] pkt_q[$];
  logic [31:0] m_exp, m_total, m_seqe, m_lene, m_sume;

  typedef struct {
    int          len;
    int          n;
    logic [31:0] seq;
    bit          corrupt;
    logic [31:0] ack1;
    logic [2:0]  st;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] mk(input logic sof, input logic eof, input logic [31:0] d);
    return {2'b00, eof, sof, d};
  endfunction

  // Packet of n words declaring length len; checksum lands at word len-1 when that word exists.
  task automatic build(input int len, input int n, input logic [31:0] seq, input bit corrupt);
    logic [31:0] s;
    logic [31:0] w;
    s = 32'd0;
    pkt_q.delete();
    for (int k = 0; k < n; k++) begin
      if (k == 0) w = 32'(len);
      else if (k == 1) w = seq;
      else if (len >= 3 && k == len - 1) w = s + 32'(corrupt);
      else w = 32'(k - 1);
      if (k < len - 1) s = s + w;
      pkt_q.push_back(mk(k == 0, k == n - 1, w));
    end
  endtask

  // Reference: status from the packet as a whole (declared vs actual length, seq, sum).
  function automatic void model_pkt(output logic [31:0] a1, output logic [2:0] st);
    int          n;
    logic [31:0] l;
    logic [31:0] s;
    n  = pkt_q.size();
    l  = pkt_q[0][31:0];
    s  = 32'd0;
    a1 = 32'd0;
    st = 3'd0;
    if (l < 32'd3 || l > 32'd2048 || n == 1) begin
      st[1] = 1'b1;
      return;
    end
    a1 = pkt_q[1][31:0];
    if (a1 != m_exp) st[2] = 1'b1;
    m_exp = a1 + 32'd1;
    if (32'(n) != l) st[1] = 1'b1;
    else begin
      for (int k = 0; k < n - 1; k++) s = s + pkt_q[k][31:0];
      st[0] = (pkt_q[n-1][31:0] != s);
    end
  endfunction

  // Drives pkt_q from a negedge; ends at the negedge following the last transfer.
  task automatic send(input bit gaps, input bit chk_lat, input string tag);
    int i;
    int cyc;
    bit v;
    bit acc;
    i   = 0;
    cyc = 0;
    while (i < pkt_q.size() && cyc < 20000) begin
      v         = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      data_i    = pkt_q[i];
      src_rdy_i = v;
      acc       = v && dst_rdy_o;
      @(negedge clk);
      cyc++;
      if (acc) i++;
    end
    src_rdy_i = 1'b0;
    data_i    = '0;
    check({tag, " words sent"}, 64'(i), 64'(pkt_q.size()));
    if (chk_lat) check({tag, " ack latency"}, 64'(src_rdy_o), 64'd1);
  endtask

  // Collects nwords ack words; mode 0 always ready, 1 toggles 1010, 2 random.
  task automatic recv(input int mode, input int nwords, input logic [31:0] a1, input logic [2:0] st,
                      input logic [31:0] tot_next, input string tag);
    logic [35:0] exp_w[4];
    logic [35:0] held;
    int          idx;
    int          cyc;
    bit          rdy;
    bit          stalled;
    exp_w[0] = mk(1'b1, 1'b0, 32'd4);
    exp_w[1] = mk(1'b0, 1'b0, a1);
    exp_w[2] = mk(1'b0, 1'b0, {29'd0, st});
    exp_w[3] = mk(1'b0, 1'b1, tot_next);
    idx      = 0;
    cyc      = 0;
    stalled  = 1'b0;
    held     = '0;
    while (idx < nwords && cyc < 200) begin
      if (src_rdy_o) check({tag, " input stalled"}, 64'(dst_rdy_o), 64'd0);
      if (stalled) check({tag, " held"}, 64'(data_o), 64'(held));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      dst_rdy_i = rdy;
      if (src_rdy_o && rdy) begin
        check($sformatf("%s ack%0d", tag, idx), 64'(data_o), 64'(exp_w[idx]));
        idx++;
      end
      held    = data_o;
      stalled = src_rdy_o && !rdy;
      @(negedge clk);
      cyc++;
    end
    dst_rdy_i = 1'b0;
    check({tag, " ack words"}, 64'(idx), 64'(nwords));
  endtask

  task automatic post(input string tag, input logic [31:0] t, input logic [31:0] se,
                      input logic [31:0] le, input logic [31:0] sm);
    check({tag, " src_rdy_o idle"}, 64'(src_rdy_o), 64'd0);
    check({tag, " dst_rdy_o ready"}, 64'(dst_rdy_o), 64'd1);
    check({tag, " total"}, 64'(total), 64'(t));
    check({tag, " seq_errs"}, 64'(seq_errs), 64'(se));
    check({tag, " len_errs"}, 64'(len_errs), 64'(le));
    check({tag, " sum_errs"}, 64'(sum_errs), 64'(sm));
  endtask

  task automatic zero_outputs(input string tag);
    check({tag, " src_rdy_o"}, 64'(src_rdy_o), 64'd0);
    check({tag, " data_o"}, 64'(data_o), 64'd0);
    check({tag, " dst_rdy_o"}, 64'(dst_rdy_o), 64'd1);
    check({tag, " total"}, 64'(total), 64'd0);
    check({tag, " errs"}, 64'(seq_errs | len_errs | sum_errs), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a1;
    logic [2:0]  st;
    logic [31:0] t_se, t_le, t_sm;
    int          len, n, kind;
    logic [31:0] seq;
    bit          corrupt;

    tbl[0]  = '{6,    6,    32'd0,  1'b0, 32'd0,  3'd0};
    tbl[1]  = '{6,    6,    32'd5,  1'b0, 32'd5,  3'd4};
    tbl[2]  = '{6,    6,    32'd6,  1'b0, 32'd6,  3'd0};
    tbl[3]  = '{6,    4,    32'd7,  1'b0, 32'd7,  3'd2};
    tbl[4]  = '{4,    7,    32'd8,  1'b0, 32'd8,  3'd2};
    tbl[5]  = '{6,    6,    32'd9,  1'b1, 32'd9,  3'd1};
    tbl[6]  = '{2,    2,    32'd10, 1'b0, 32'd0,  3'd2};
    tbl[7]  = '{1,    1,    32'd10, 1'b0, 32'd0,  3'd2};
    tbl[8]  = '{2049, 3,    32'd10, 1'b0, 32'd0,  3'd2};
    tbl[9]  = '{3,    3,    32'd10, 1'b0, 32'd10, 3'd0};
    tbl[10] = '{2048, 2048, 32'd11, 1'b0, 32'd11, 3'd0};

    reset_n   = 1'b0;
    clear     = 1'b0;
    src_rdy_i = 1'b0;
    dst_rdy_i = 1'b0;
    data_i    = '0;
    repeat (3) @(negedge clk);
    zero_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    t_se = 0; t_le = 0; t_sm = 0;
    for (int i = 0; i < 11; i++) begin
      build(tbl[i].len, tbl[i].n, tbl[i].seq, tbl[i].corrupt);
      send(1'b0, 1'b1, $sformatf("vec%0d", i));
      recv(0, 4, tbl[i].ack1, tbl[i].st, 32'(i + 1), $sformatf("vec%0d", i));
      t_se = t_se + 32'(tbl[i].st[2]);
      t_le = t_le + 32'(tbl[i].st[1]);
      t_sm = t_sm + 32'(tbl[i].st[0]);
      post($sformatf("vec%0d", i), 32'(i + 1), t_se, t_le, t_sm);
    end

    build(5, 5, 32'd12, 1'b0);
    send(1'b0, 1'b1, "bp");
    recv(1, 4, 32'd12, 3'd0, 32'd12, "bp");
    post("bp", 32'd12, t_se, t_le, t_sm);

    // Async reset in the middle of a packet body
    build(6, 6, 32'd13, 1'b0);
    while (pkt_q.size() > 3) void'(pkt_q.pop_back());
    send(1'b0, 1'b0, "rst_part");
    #2 reset_n = 1'b0;
    #1 zero_outputs("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    build(6, 6, 32'd0, 1'b0);
    send(1'b0, 1'b1, "post_rst");
    recv(0, 4, 32'd0, 3'd0, 32'd1, "post_rst");
    post("post_rst", 32'd1, 0, 0, 0);

    // Clear while ack1 is presented
    build(6, 6, 32'd1, 1'b0);
    send(1'b0, 1'b1, "clr");
    recv(0, 1, 32'd1, 3'd0, 32'd2, "clr");
    check("clr ack1 shown", 64'(data_o), 64'(mk(1'b0, 1'b0, 32'd1)));
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    zero_outputs("clr");
    build(6, 6, 32'd0, 1'b0);
    send(1'b0, 1'b1, "post_clr");
    recv(0, 4, 32'd0, 3'd0, 32'd1, "post_clr");
    post("post_clr", 32'd1, 0, 0, 0);

    m_exp = 32'd1; m_total = 32'd1; m_seqe = 0; m_lene = 0; m_sume = 0;
    for (int r = 0; r < 60; r++) begin
      kind    = $urandom_range(0, 5);
      len     = $urandom_range(3, 12);
      n       = len;
      seq     = m_exp;
      corrupt = 1'b0;
      case (kind)
        1: seq = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'($urandom());
        2: corrupt = 1'b1;
        3: n = $urandom_range(1, len - 1);
        4: n = len + $urandom_range(1, 4);
        5: begin
          len = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 2) : 2049 + $urandom_range(0, 1000);
          n   = $urandom_range(1, 4);
        end
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        pkt_q.delete();
        pkt_q.push_back(mk(1'b0, 1'($urandom_range(0, 1)), 32'($urandom())));
        send(1'b1, 1'b0, "stray");
      end
      build(len, n, seq, corrupt);
      model_pkt(a1, st);
      send(1'b1, 1'b1, $sformatf("rnd%0d", r));
      recv(2, 4, a1, st, m_total + 32'd1, $sformatf("rnd%0d", r));
      m_total = m_total + 32'd1;
      m_seqe  = m_seqe + 32'(st[2]);
      m_lene  = m_lene + 32'(st[1]);
      m_sume  = m_sume + 32'(st[0]);
      post($sformatf("rnd%0d", r), m_total, m_seqe, m_lene, m_sume);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
